main_mem: RTL and testbench

MAIN_MEM -- requirements
Module: main_mem

---
 rtl/main_mem.sv | 140 ++++++++++++++
 tb/tb_main_mem.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/main_mem.sv
// Fixed-latency block memory: one request per cycle, in-order responses through a
// LATENCY-deep {valid, cache_type, data} pipeline, with sticky range error and saturating counters.
package main_mem_pkg;
    typedef enum logic {ICACHE = 1'b0, DCACHE = 1'b1} cache_type_t;
    typedef enum logic {READ = 1'b0, WRITE = 1'b1} req_type_t;
    typedef logic [15:0] main_mem_block_addr_t;
    typedef logic [31:0] block_data_t;
endpackage

module main_mem
    import main_mem_pkg::*;
#(
    parameter int LATENCY    = 4,
    parameter int NUM_BLOCKS = 256,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 mem_req_valid,
    input  cache_type_t          mem_req_cache_type,
    input  req_type_t            mem_req_type,
    input  main_mem_block_addr_t mem_req_block_addr,
    input  block_data_t          mem_req_block_data,
    output logic                 mem_resp_valid,
    output cache_type_t          mem_resp_cache_type,
    output block_data_t          mem_resp_block_data,
    output logic                 addr_err,
    output logic [CNT_WIDTH-1:0] rd_count,
    output logic [CNT_WIDTH-1:0] wr_count
);
    localparam int IDX_W = $clog2(NUM_BLOCKS);

    logic [IDX_W-1:0] req_idx;
    logic             req_in_range;
    logic             req_is_rd;
    logic             req_is_wr;
    logic             ram_we;

    assign req_idx      = mem_req_block_addr[IDX_W-1:0];
    assign req_in_range = (mem_req_block_addr >> IDX_W) == '0;
    assign req_is_rd    = mem_req_valid && (mem_req_type == READ);
    assign req_is_wr    = mem_req_valid && (mem_req_type == WRITE);
    // rst_n gates the write so requests presented during reset cannot touch the array.
    assign ram_we       = rst_n && req_is_wr && req_in_range;

    block_data_t mem_array [NUM_BLOCKS];
    block_data_t ram_rd_q;

    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem_array[req_idx] <= mem_req_block_data;
        end
        ram_rd_q <= mem_array[req_idx];
    end

    logic                 s0_valid_q,  s0_valid_d;
    cache_type_t          s0_ct_q,     s0_ct_d;
    logic                 s0_rd_sel_q, s0_rd_sel_d;
    block_data_t          s0_wdata_q,  s0_wdata_d;
    logic                 addr_err_q,  addr_err_d;
    logic [CNT_WIDTH-1:0] rd_count_q,  rd_count_d;
    logic [CNT_WIDTH-1:0] wr_count_q,  wr_count_d;

    always_comb begin
        s0_valid_d  = mem_req_valid;
        s0_ct_d     = mem_req_valid ? mem_req_cache_type : ICACHE;
        s0_rd_sel_d = req_is_rd && req_in_range;
        s0_wdata_d  = req_is_wr ? mem_req_block_data : '0;
        addr_err_d  = addr_err_q || (mem_req_valid && !req_in_range);
        rd_count_d  = rd_count_q;
        wr_count_d  = wr_count_q;
        if (req_is_rd && !(&rd_count_q)) begin
            rd_count_d = rd_count_q + CNT_WIDTH'(1);
        end
        if (req_is_wr && !(&wr_count_q)) begin
            wr_count_d = wr_count_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0_valid_q  <= 1'b0;
            s0_ct_q     <= ICACHE;
            s0_rd_sel_q <= 1'b0;
            s0_wdata_q  <= '0;
            addr_err_q  <= 1'b0;
            rd_count_q  <= '0;
            wr_count_q  <= '0;
        end else begin
            s0_valid_q  <= s0_valid_d;
            s0_ct_q     <= s0_ct_d;
            s0_rd_sel_q <= s0_rd_sel_d;
            s0_wdata_q  <= s0_wdata_d;
            addr_err_q  <= addr_err_d;
            rd_count_q  <= rd_count_d;
            wr_count_q  <= wr_count_d;
        end
    end

    logic        tap_valid [LATENCY];
    cache_type_t tap_ct    [LATENCY];
    block_data_t tap_data  [LATENCY];

    // Stage 0 merges the registered RAM read with write-ack data; idle stages carry zeros.
    assign tap_valid[0] = s0_valid_q;
    assign tap_ct[0]    = s0_ct_q;
    assign tap_data[0]  = s0_rd_sel_q ? ram_rd_q : s0_wdata_q;

    genvar gi;
    generate
        for (gi = 1; gi < LATENCY; gi++) begin : g_stage
            logic        valid_q;
            cache_type_t ct_q;
            block_data_t data_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    valid_q <= 1'b0;
                    ct_q    <= ICACHE;
                    data_q  <= '0;
                end else begin
                    valid_q <= tap_valid[gi-1];
                    ct_q    <= tap_ct[gi-1];
                    data_q  <= tap_data[gi-1];
                end
            end

            assign tap_valid[gi] = valid_q;
            assign tap_ct[gi]    = ct_q;
            assign tap_data[gi]  = data_q;
        end
    endgenerate

    assign mem_resp_valid      = tap_valid[LATENCY-1];
    assign mem_resp_cache_type = tap_ct[LATENCY-1];
    assign mem_resp_block_data = tap_data[LATENCY-1];
    assign addr_err            = addr_err_q;
    assign rd_count            = rd_count_q;
    assign wr_count            = wr_count_q;
endmodule

// File: tb/tb_main_mem.sv
// Directed bench for main_mem: a reference array and a due-cycle scoreboard predict every
// response; a negedge monitor checks each cycle for the expected response or an idle bus.
module tb_main_mem;
    import main_mem_pkg::*;

    localparam int LAT = 4;
    localparam int NB  = 256;
    localparam int CW  = 4;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 mem_req_valid = 1'b0;
    cache_type_t          mem_req_cache_type = ICACHE;
    req_type_t            mem_req_type = READ;
    main_mem_block_addr_t mem_req_block_addr = '0;
    block_data_t          mem_req_block_data = '0;
    logic                 mem_resp_valid;
    cache_type_t          mem_resp_cache_type;
    block_data_t          mem_resp_block_data;
    logic                 addr_err;
    logic [CW-1:0]        rd_count;
    logic [CW-1:0]        wr_count;

    main_mem #(.LATENCY(LAT), .NUM_BLOCKS(NB), .CNT_WIDTH(CW)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .mem_req_valid       (mem_req_valid),
        .mem_req_cache_type  (mem_req_cache_type),
        .mem_req_type        (mem_req_type),
        .mem_req_block_addr  (mem_req_block_addr),
        .mem_req_block_data  (mem_req_block_data),
        .mem_resp_valid      (mem_resp_valid),
        .mem_resp_cache_type (mem_resp_cache_type),
        .mem_resp_block_data (mem_resp_block_data),
        .addr_err            (addr_err),
        .rd_count            (rd_count),
        .wr_count            (wr_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        cache_type_t ct;
        block_data_t data;
    } exp_t;

    exp_t        sb[$];
    block_data_t model [NB];
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;
    int          rd_exp = 0;
    int          wr_exp = 0;
    logic        err_exp = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].due < cyc) begin
            checks++;
            failures++;
            $error("FAIL missed_resp observed=none expected_cycle=%0d", sb[0].due);
            void'(sb.pop_front());
        end
        if (sb.size() > 0 && sb[0].due == cyc) begin
            chk("resp_valid", 32'(mem_resp_valid), 32'd1);
            chk("resp_ct", 32'(mem_resp_cache_type), 32'(sb[0].ct));
            chk("resp_data", mem_resp_block_data, sb[0].data);
            $display("resp cyc=%0d ct=%0d data=0x%0h exp_ct=%0d exp_data=0x%0h",
                     cyc, mem_resp_cache_type, mem_resp_block_data, sb[0].ct, sb[0].data);
            void'(sb.pop_front());
        end else begin
            chk("idle_valid", 32'(mem_resp_valid), 32'd0);
            chk("idle_ct", 32'(mem_resp_cache_type), 32'd0);
            chk("idle_data", mem_resp_block_data, 32'd0);
        end
    end

    task automatic issue(input cache_type_t ct, input req_type_t rt,
                         input logic [15:0] a, input logic [31:0] d);
        exp_t e;
        logic inr;
        @(negedge clk);
        mem_req_valid      = 1'b1;
        mem_req_cache_type = ct;
        mem_req_type       = rt;
        mem_req_block_addr = a;
        mem_req_block_data = d;
        inr = (a < 16'(NB));
        e.due = cyc + LAT;
        e.ct  = ct;
        if (rt == WRITE) begin
            e.data = d;
            if (inr) model[a[7:0]] = d;
            if (wr_exp < 15) wr_exp++;
        end else begin
            e.data = inr ? model[a[7:0]] : 32'd0;
            if (rd_exp < 15) rd_exp++;
        end
        sb.push_back(e);
        $display("req cyc=%0d ct=%0d type=%0d addr=0x%0h data=0x%0h", cyc, ct, rt, a, d);
        if (!inr) err_exp = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            mem_req_valid      = 1'b0;
            mem_req_block_data = '0;
        end
    endtask

    task automatic check_status(input string tag);
        chk({tag, "_rd_count"}, 32'(rd_count), 32'(rd_exp));
        chk({tag, "_wr_count"}, 32'(wr_count), 32'(wr_exp));
        chk({tag, "_addr_err"}, 32'(addr_err), 32'(err_exp));
    endtask

    task automatic drain(input string tag);
        int budget = 0;
        while (sb.size() > 0 && budget < 50) begin
            idle(1);
            budget++;
        end
        checks++;
        assert (sb.size() == 0) else begin
            failures++;
            $error("FAIL %s_drain observed=%0d_pending expected=0_pending", tag, sb.size());
        end
        sb.delete();
    endtask

    // Assert reset just after a rising edge; requests keep arriving while it is low.
    task automatic do_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        sb.delete();
        rd_exp  = 0;
        wr_exp  = 0;
        err_exp = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            mem_req_valid      = 1'b1;
            mem_req_cache_type = DCACHE;
            mem_req_type       = WRITE;
            mem_req_block_addr = 16'h0010;
            mem_req_block_data = 32'hBAD0 + 32'(i);
            check_status("in_reset");
        end
        @(negedge clk);
        rst_n         = 1'b1;
        mem_req_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle(3);
        check_status("reset");
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);
        check_status("post_reset");

        issue(DCACHE, WRITE, 16'h0010, 32'h0000A5A5);
        issue(ICACHE, READ,  16'h0010, 32'h0);
        drain("wr_then_rd");

        for (int i = 0; i < 8; i++) issue(DCACHE, WRITE, 16'(i), 32'h100 + 32'(i));
        issue(ICACHE, WRITE, 16'h0020, 32'h11);
        issue(DCACHE, WRITE, 16'h00FF, 32'hFFEE);
        drain("preload");
        do_reset();
        for (int i = 0; i < 8; i++) issue(ICACHE, READ, 16'(i), 32'h0);
        idle(1);
        check_status("burst8");
        drain("burst8");

        issue(ICACHE, READ,  16'h0020, 32'h0);
        issue(DCACHE, READ,  16'h0020, 32'h0);
        issue(ICACHE, WRITE, 16'h0020, 32'h22);
        issue(DCACHE, READ,  16'h0020, 32'h0);
        issue(ICACHE, READ,  16'h0020, 32'h0);
        issue(DCACHE, READ,  16'h00FF, 32'h0);
        drain("interleave");

        issue(DCACHE, WRITE, 16'h0000, 32'hCAFE);
        chk("err_before_oor", 32'(addr_err), 32'd0);
        issue(ICACHE, READ,  16'h0100, 32'h0);
        idle(1);
        chk("err_after_oor", 32'(addr_err), 32'd1);
        issue(DCACHE, WRITE, 16'h0100, 32'hDEAD);
        issue(ICACHE, READ,  16'h0000, 32'h0);
        issue(DCACHE, READ,  16'h8000, 32'h0);
        drain("oor");
        check_status("oor_held");

        issue(ICACHE, READ, 16'h0001, 32'h0);
        issue(DCACHE, READ, 16'h0002, 32'h0);
        do_reset();
        idle(LAT + 2);
        check_status("inflight_reset");
        issue(ICACHE, READ, 16'h0010, 32'h0);
        issue(DCACHE, READ, 16'h0003, 32'h0);
        drain("persist");

        for (int i = 0; i < 20; i++) issue(DCACHE, WRITE, 16'h40 + 16'(i), 32'h5000 + 32'(i));
        idle(1);
        chk("wr_sat_value", 32'(wr_count), 32'd15);
        check_status("wr_sat");
        issue(ICACHE, READ, 16'h0053, 32'h0);
        drain("wr_sat");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
